muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the execute stage of the 5-stage pipeline. It takes forwarded operands and a decoded mult/div opcode from the execute pipeline register outputs. It runs one radix-2 step per cycle and raises `busy` so the hazard unit holds the fetch, decode and execute registers until the result is in HI/LO. MFHI/MFLO read the `hi`/`lo` outputs directly in execute.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit that owns the architectural HI/LO
// registers. One step runs per cycle, and busy stalls the front of the pipeline.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op_e,
  input  logic [31:0] srca_e,
  input  logic [31:0] srcb_e,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] opd;
  logic [31:0] a_raw;
  logic [63:0] acc;
  logic [31:0] rem;

  logic        start;
  logic        start_div;
  logic        start_sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_s;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ok;
  logic [31:0] div_rem_next;
  logic [31:0] div_q_next;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Handshake: busy is a pure stall request. It is high while a mult/div is
  // pending in IDLE or stepping in RUN. It falls in DONE so the held
  // instruction can leave execute, and it is never high while reset is low.
  always_comb begin
    start     = (op_e == OP_MULT) || (op_e == OP_MULTU) ||
                (op_e == OP_DIV)  || (op_e == OP_DIVU);
    start_div = (op_e == OP_DIV) || (op_e == OP_DIVU);
    start_sgn = (op_e == OP_MULT) || (op_e == OP_DIV);
    busy      = reset && ((state == S_RUN) || ((state == S_IDLE) && start));
    dbg_state = state;
  end

  always_comb begin
    a_mag = (start_sgn && srca_e[31]) ? (32'd0 - srca_e) : srca_e;
    b_mag = (start_sgn && srcb_e[31]) ? (32'd0 - srcb_e) : srcb_e;
  end

  // Multiply: the multiplier sits in acc[31:0] and shifts out LSB first.
  // The multiplicand is added into the upper half.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    prod_s   = neg_q ? (64'd0 - mul_next) : mul_next;
  end

  // Divide: restoring. The dividend/quotient shifts through acc[31:0].
  always_comb begin
    div_shift    = {rem, acc[31]};
    div_diff     = div_shift - {1'b0, opd};
    div_ok       = ~div_diff[32];
    div_rem_next = div_ok ? div_diff[31:0] : div_shift[31:0];
    div_q_next   = {acc[30:0], div_ok};
  end

  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    if (is_div) begin
      if (opd == 32'd0) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_lo = neg_q ? (32'd0 - div_q_next) : div_q_next;
        res_hi = neg_r ? (32'd0 - div_rem_next) : div_rem_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opd    <= 32'd0;
      a_raw  <= 32'd0;
      acc    <= 64'd0;
      rem    <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= start_div;
            neg_q  <= start_sgn && (srca_e[31] ^ srcb_e[31]);
            neg_r  <= start_sgn && srca_e[31];
            opd    <= start_div ? b_mag : a_mag;
            acc    <= {32'd0, (start_div ? a_mag : b_mag)};
            rem    <= 32'd0;
            a_raw  <= srca_e;
            cnt    <= 5'd0;
            state  <= S_RUN;
          end else if (op_e == OP_MTHI) begin
            hi <= srca_e;
          end else if (op_e == OP_MTLO) begin
            lo <= srca_e;
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc[31:0] <= div_q_next;
            rem       <= div_rem_next;
          end else begin
            acc <= mul_next;
          end
          if (cnt == 5'd31) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit. The driver pushes each mult/div's expected
// {stall length, hi, lo}, and the monitor pops and checks when the stall ends.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  op_e;
  logic [31:0] srca_e;
  logic [31:0] srcb_e;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic [1:0]  dbg_state;

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;
  localparam logic [2:0] MTHI  = 3'b101;
  localparam logic [2:0] MTLO  = 3'b110;

  int n_tests = 0;
  int n_fail  = 0;
  logic [95:0] exp_q[$];

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .op_e      (op_e),
    .srca_e    (srca_e),
    .srcb_e    (srcb_e),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: measures each busy run and compares the result seen in DONE
  int run_len = 0;
  always @(negedge clk) begin
    logic [95:0] e;
    if (!reset) begin
      run_len = 0;
    end else if (busy) begin
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy_run", 64'(run_len), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("busy_len", 64'(run_len), 64'(e[95:64]));
        check("hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
      run_len = 0;
    end
  end

  // driver tasks
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    op_e = op;
    srca_e = a;
    srcb_e = b;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    bit done;
    done = 0;
    exp_q.push_back({32'd33, ehi, elo});
    drive(op, a, b);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) check("stall_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    op_e = NONE;
    srca_e = 32'd0;
    srcb_e = 32'd0;
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // MTHI then MTLO on consecutive cycles
    drive(MTHI, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    drive(MTLO, 32'h0BAD_F00D, 32'd0);
    @(negedge clk);
    check("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    drive(NONE, 32'd0, 32'd0);
    @(negedge clk);
    check("mtlo_lo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});
    check("mt_hi_held", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});

    // reset asserted in RUN cycle 10
    drive(MULT, 32'h1234_5678, 32'd9);
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrun_busy", {63'd0, busy}, 64'd0);
    check("midrun_hi", {32'd0, hi}, 64'd0);
    check("midrun_lo", {32'd0, lo}, 64'd0);
    check("midrun_state", {62'd0, dbg_state}, 64'd0);
    op_e = NONE;
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_state", {62'd0, dbg_state}, 64'd0);
      check("post_rst_busy", {63'd0, busy}, 64'd0);
    end

    run_op(MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    drive(NONE, 32'd0, 32'd0);
    run_op(MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    drive(NONE, 32'd0, 32'd0);
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    drive(NONE, 32'd0, 32'd0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drive(NONE, 32'd0, 32'd0);
    run_op(DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    drive(NONE, 32'd0, 32'd0);
    run_op(DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
    drive(NONE, 32'd0, 32'd0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    drive(NONE, 32'd0, 32'd0);
    run_op(DIVU,  32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    drive(NONE, 32'd0, 32'd0);

    // back-to-back: second op presented the cycle after DONE
    run_op(MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    run_op(MULTU, 32'd2, 32'd2, 32'd0, 32'd4);
    drive(NONE, 32'd0, 32'd0);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_state", {62'd0, dbg_state}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
